fm_axi_master: RTL and testbench
================================

Name: fm_axi_master

Overview:
Single-beat AXI4 initiator that drives the FM register map slave (FM_map) from a simple command/response interface.
- Used by on-chip control logic and by simulation benches to issue register reads and writes.
- Exposes the AXI bus as flattened master_* ports, so it connects field-for-field to the slave-side flattened wrapper.
- One transaction in flight at a time.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width.
AXI_ID_BIT_COUNT, 6, AXI ID width.
AXI_ID, 0, constant ID driven on ARID/AWID/WID and expected on RID/BID.
TIMEOUT_CYCLES, 1024, watchdog limit per AXI phase; used only with FM_AXI_MASTER_TIMEOUT_EN.

Ports:
clk_axi  in  1  AXI clock; all logic on rising edge.
reset_axi  in  1  synchronous, active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  AXI_ADDR_WIDTH  byte address.
cmd_wdata  in  32  write data.
cmd_wstrb  in  4  write byte strobes.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
rsp_rdata  out  32  read data; 0 for writes.
rsp_resp  out  2  RRESP/BRESP as received; 2'b10 on timeout.
rsp_err  out  1  ID mismatch, missing RLAST, or timeout.
master_readMOSI_{address,address_ID,address_valid,ready_for_data}  out  per AXI  ARADDR/ARID/ARVALID/RREADY.
master_readMOSI_{protection_type,burst_length,burst_size,burst_type,lock_type,cache_type,qos,region,address_user}  out  per AXI  constants: 0,0,3'b010,2'b01,0,0,0,0,0.
master_readMISO_{ready_for_address,data_ID,data,data_valid,response,last,data_user}  in  per AXI  ARREADY/RID/RDATA/RVALID/RRESP/RLAST/RUSER (RUSER ignored).
master_writeMOSI_{address,address_ID,address_valid,write_ID,data,data_valid,data_write_strobe,last,ready_for_response}  out  per AXI  AW/W/BREADY; last tied 1.
master_writeMOSI_{protection_type,burst_length,burst_size,burst_type,lock_type,cache_type,qos,region,address_user,data_user}  out  per AXI  constants as read side; data_user 0.
master_writeMISO_{ready_for_address,ready_for_data,response_ID,response_valid,response,response_user}  in  per AXI  AWREADY/WREADY/BID/BVALID/BRESP/BUSER (BUSER ignored).

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP.
- Reset: state=IDLE. All VALID/READY outputs 0, cmd_ready=0, rsp_valid=0, rsp_* =0, address/data registers 0.
  - Reset mid-transaction abandons it immediately; no response is produced.
- IDLE: cmd_ready=1 (registered). On accept, latch addr/wdata/wstrb. Next state is WR_REQ or RD_ADDR.
  - AXI VALIDs rise the cycle after accept.
- WR_REQ:
  - AWVALID and WVALID assert together.
  - Each deasserts on its own handshake (AWVALID&&AWREADY, WVALID&&WREADY). Payload stays stable while VALID is high.
  - Move to WR_RESP when both handshakes are done, including both in the same cycle or in either order.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and set rsp_err if BID!=AXI_ID. Go to RSP.
- RD_ADDR: ARVALID=1 until ARREADY. Then RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA/RRESP. Set rsp_err if RID!=AXI_ID or RLAST=0. Go to RSP.
- RSP: rsp_valid=1, fields held stable until rsp_ready. Then IDLE with cmd_ready=1 the following cycle.
- No VALID ever depends combinationally on a READY. Outputs are registered.
- Minimum latency, zero-wait slave: accept->rsp_valid is 3 cycles for a read and 3 cycles for a write.
- Back-to-back commands are spaced by ≥1 idle cycle.

Optional Feature:
FM_AXI_MASTER_TIMEOUT_EN:
- Defined: counter reset on each state entry. If the count reaches TIMEOUT_CYCLES in WR_REQ, WR_RESP, RD_ADDR or RD_DATA:
  - drop all VALID/READY outputs;
  - rsp_resp=2'b10, rsp_err=1, rsp_rdata=0;
  - go to RSP.
- Undefined: no counter. The block waits indefinitely in every state.

Decomposition:
- Package fm_axi_master_pkg holds:
  - state enum fm_axi_mst_state_t;
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11;
  - AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010.
- Sub-module fm_axi_master_wdog holds the timeout counter, instantiated only under FM_AXI_MASTER_TIMEOUT_EN. Everything else stays in the top.

Test Plan:
- Write addr 0x0000_0010, data 0xDEADBEEF, wstrb 0xF; slave asserts WREADY 2 cycles before AWREADY -> AW and W payloads each seen exactly once; BRESP 00 -> rsp_valid with rsp_resp=00, rsp_err=0.
- Read addr 0x0000_0010; slave returns RDATA 0xDEADBEEF, RLAST=1, RID=AXI_ID after 5 wait cycles -> rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Read answered with RRESP=2'b11, RID=AXI_ID+1 -> rsp_resp=11, rsp_err=1.
- rsp_ready held low 10 cycles -> rsp_* stable, cmd_ready=0 throughout; cmd_ready=1 the cycle after rsp_ready.
- reset_axi pulsed while in RD_DATA -> all outputs 0 the next cycle; no rsp_valid; a new write then completes normally.
- With FM_AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, ARREADY held 0 -> rsp_valid with rsp_resp=10, rsp_err=1; ARVALID low from then on.

Source files
------------

// File: rtl/fm_axi_master_pkg.sv
// Shared types and AXI encodings for the single-beat FM register-map initiator.
package fm_axi_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_RSP
   } fm_axi_mst_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

   localparam int unsigned AXI_USER_WIDTH = 1;

   // States in which the block waits on the AXI slave.
   function automatic logic is_wait_state(input fm_axi_mst_state_t s);
      return (s == ST_WR_REQ) || (s == ST_WR_RESP) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
   endfunction

endpackage

// File: rtl/fm_axi_master_wdog.sv
// Per-phase watchdog for fm_axi_master; only built when FM_AXI_MASTER_TIMEOUT_EN is defined.
`ifdef FM_AXI_MASTER_TIMEOUT_EN
module fm_axi_master_wdog
   import fm_axi_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  fm_axi_mst_state_t state,
   output logic              expired
);

   localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   fm_axi_mst_state_t prev_state;
   logic [CW-1:0]     count;
   logic [CW-1:0]     elapsed;
   logic              restart;

   // A state change is seen one cycle late, so the entry cycle counts as zero.
   always_comb begin
      restart = (state != prev_state);
      elapsed = restart ? '0 : count;
      expired = is_wait_state(state) && (elapsed == LIMIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_state <= ST_IDLE;
         count      <= '0;
      end else begin
         prev_state <= state;
         if (restart) begin
            count <= CW'(1);
         end else if (count != LIMIT) begin
            count <= count + CW'(1);
         end
      end
   end

endmodule
`endif

// File: rtl/fm_axi_master.sv
// Single-beat AXI4 initiator for the FM register map, driven by a command/response port.
// Optional per-phase watchdog enabled by defining FM_AXI_MASTER_TIMEOUT_EN.
module fm_axi_master
   import fm_axi_master_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH   = 32,
   parameter int unsigned AXI_ID_BIT_COUNT = 6,
   parameter int unsigned AXI_ID           = 0,
   parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
   input  logic                        clk_axi,
   input  logic                        reset_axi,

   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [31:0]                 cmd_wdata,
   input  logic [3:0]                  cmd_wstrb,

   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [31:0]                 rsp_rdata,
   output logic [1:0]                  rsp_resp,
   output logic                        rsp_err,

   output logic [AXI_ADDR_WIDTH-1:0]   master_readMOSI_address,
   output logic [AXI_ID_BIT_COUNT-1:0] master_readMOSI_address_ID,
   output logic                        master_readMOSI_address_valid,
   output logic                        master_readMOSI_ready_for_data,
   output logic [2:0]                  master_readMOSI_protection_type,
   output logic [7:0]                  master_readMOSI_burst_length,
   output logic [2:0]                  master_readMOSI_burst_size,
   output logic [1:0]                  master_readMOSI_burst_type,
   output logic                        master_readMOSI_lock_type,
   output logic [3:0]                  master_readMOSI_cache_type,
   output logic [3:0]                  master_readMOSI_qos,
   output logic [3:0]                  master_readMOSI_region,
   output logic [AXI_USER_WIDTH-1:0]   master_readMOSI_address_user,

   input  logic                        master_readMISO_ready_for_address,
   input  logic [AXI_ID_BIT_COUNT-1:0] master_readMISO_data_ID,
   input  logic [31:0]                 master_readMISO_data,
   input  logic                        master_readMISO_data_valid,
   input  logic [1:0]                  master_readMISO_response,
   input  logic                        master_readMISO_last,
   input  logic [AXI_USER_WIDTH-1:0]   master_readMISO_data_user,

   output logic [AXI_ADDR_WIDTH-1:0]   master_writeMOSI_address,
   output logic [AXI_ID_BIT_COUNT-1:0] master_writeMOSI_address_ID,
   output logic                        master_writeMOSI_address_valid,
   output logic [AXI_ID_BIT_COUNT-1:0] master_writeMOSI_write_ID,
   output logic [31:0]                 master_writeMOSI_data,
   output logic                        master_writeMOSI_data_valid,
   output logic [3:0]                  master_writeMOSI_data_write_strobe,
   output logic                        master_writeMOSI_last,
   output logic                        master_writeMOSI_ready_for_response,
   output logic [2:0]                  master_writeMOSI_protection_type,
   output logic [7:0]                  master_writeMOSI_burst_length,
   output logic [2:0]                  master_writeMOSI_burst_size,
   output logic [1:0]                  master_writeMOSI_burst_type,
   output logic                        master_writeMOSI_lock_type,
   output logic [3:0]                  master_writeMOSI_cache_type,
   output logic [3:0]                  master_writeMOSI_qos,
   output logic [3:0]                  master_writeMOSI_region,
   output logic [AXI_USER_WIDTH-1:0]   master_writeMOSI_address_user,
   output logic [AXI_USER_WIDTH-1:0]   master_writeMOSI_data_user,

   input  logic                        master_writeMISO_ready_for_address,
   input  logic                        master_writeMISO_ready_for_data,
   input  logic [AXI_ID_BIT_COUNT-1:0] master_writeMISO_response_ID,
   input  logic                        master_writeMISO_response_valid,
   input  logic [1:0]                  master_writeMISO_response,
   input  logic [AXI_USER_WIDTH-1:0]   master_writeMISO_response_user
);

   localparam logic [AXI_ID_BIT_COUNT-1:0] ID = AXI_ID_BIT_COUNT'(AXI_ID);

   fm_axi_mst_state_t         state;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [31:0]               wdata_q;
   logic [3:0]                wstrb_q;
   logic                      arvalid_q;
   logic                      rready_q;
   logic                      awvalid_q;
   logic                      wvalid_q;
   logic                      bready_q;
   logic                      aw_done;
   logic                      w_done;
   logic                      timeout;
   logic                      unused_inputs;

`ifdef FM_AXI_MASTER_TIMEOUT_EN
   fm_axi_master_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (clk_axi),
      .reset  (reset_axi),
      .state  (state),
      .expired(timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   assign unused_inputs = ^{master_readMISO_data_user, master_writeMISO_response_user,
                            (TIMEOUT_CYCLES == 0)};

   // AW and W complete independently; a channel counts as done once its VALID has dropped.
   always_comb begin
      aw_done = !awvalid_q || master_writeMISO_ready_for_address;
      w_done  = !wvalid_q  || master_writeMISO_ready_for_data;
   end

   always_ff @(posedge clk_axi) begin
      if (reset_axi) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= '0;
         rsp_err   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
      end else if (timeout) begin
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= AXI_RESP_SLVERR;
         rsp_err   <= 1'b1;
         rsp_valid <= 1'b1;
         state     <= ST_RSP;
      end else begin
         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  addr_q    <= cmd_addr;
                  wdata_q   <= cmd_wdata;
                  wstrb_q   <= cmd_wstrb;
                  rsp_rdata <= '0;
                  rsp_resp  <= AXI_RESP_OKAY;
                  rsp_err   <= 1'b0;
                  if (cmd_write) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state     <= ST_WR_REQ;
                  end else begin
                     arvalid_q <= 1'b1;
                     state     <= ST_RD_ADDR;
                  end
               end
            end
            ST_WR_REQ: begin
               if (awvalid_q && master_writeMISO_ready_for_address) awvalid_q <= 1'b0;
               if (wvalid_q && master_writeMISO_ready_for_data) wvalid_q <= 1'b0;
               if (aw_done && w_done) begin
                  bready_q <= 1'b1;
                  state    <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (master_writeMISO_response_valid) begin
                  bready_q  <= 1'b0;
                  rsp_resp  <= master_writeMISO_response;
                  rsp_err   <= (master_writeMISO_response_ID != ID);
                  rsp_valid <= 1'b1;
                  state     <= ST_RSP;
               end
            end
            ST_RD_ADDR: begin
               if (master_readMISO_ready_for_address) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (master_readMISO_data_valid) begin
                  rready_q  <= 1'b0;
                  rsp_rdata <= master_readMISO_data;
                  rsp_resp  <= master_readMISO_response;
                  rsp_err   <= (master_readMISO_data_ID != ID) || !master_readMISO_last;
                  rsp_valid <= 1'b1;
                  state     <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign master_readMOSI_address         = addr_q;
   assign master_readMOSI_address_ID      = ID;
   assign master_readMOSI_address_valid   = arvalid_q;
   assign master_readMOSI_ready_for_data  = rready_q;
   assign master_readMOSI_protection_type = '0;
   assign master_readMOSI_burst_length    = '0;
   assign master_readMOSI_burst_size      = AXI_SIZE_4B;
   assign master_readMOSI_burst_type      = AXI_BURST_INCR;
   assign master_readMOSI_lock_type       = 1'b0;
   assign master_readMOSI_cache_type      = '0;
   assign master_readMOSI_qos             = '0;
   assign master_readMOSI_region          = '0;
   assign master_readMOSI_address_user    = '0;

   assign master_writeMOSI_address            = addr_q;
   assign master_writeMOSI_address_ID         = ID;
   assign master_writeMOSI_address_valid      = awvalid_q;
   assign master_writeMOSI_write_ID           = ID;
   assign master_writeMOSI_data               = wdata_q;
   assign master_writeMOSI_data_valid         = wvalid_q;
   assign master_writeMOSI_data_write_strobe  = wstrb_q;
   assign master_writeMOSI_last               = 1'b1;
   assign master_writeMOSI_ready_for_response = bready_q;
   assign master_writeMOSI_protection_type    = '0;
   assign master_writeMOSI_burst_length       = '0;
   assign master_writeMOSI_burst_size         = AXI_SIZE_4B;
   assign master_writeMOSI_burst_type         = AXI_BURST_INCR;
   assign master_writeMOSI_lock_type          = 1'b0;
   assign master_writeMOSI_cache_type         = '0;
   assign master_writeMOSI_qos                = '0;
   assign master_writeMOSI_region             = '0;
   assign master_writeMOSI_address_user       = '0;
   assign master_writeMOSI_data_user          = '0;

endmodule

// File: tb/tb_fm_axi_master.sv
// Self-checking bench for fm_axi_master: cycle-stepped AXI slave model plus response scoreboard.
module tb_fm_axi_master;
   import fm_axi_master_pkg::*;

   localparam int unsigned AW  = 32;
   localparam int unsigned IDW = 6;
   localparam int unsigned MID = 5;
   localparam int unsigned TO  = 16;

   logic clk_axi = 1'b0;
   logic reset_axi;
   always #5 clk_axi = ~clk_axi;

   logic          cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_err;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata, rsp_rdata;
   logic [3:0]    cmd_wstrb;
   logic [1:0]    rsp_resp;

   logic [AW-1:0]  ar_addr, aw_addr;
   logic [IDW-1:0] ar_id, aw_id, w_id, r_id, b_id;
   logic           ar_valid, r_ready, ar_lock, aw_valid, w_valid, w_last, b_ready, aw_lock;
   logic [2:0]     ar_prot, ar_size, aw_prot, aw_size;
   logic [7:0]     ar_len, aw_len;
   logic [1:0]     ar_burst, aw_burst, r_resp, b_resp;
   logic [3:0]     ar_cache, ar_qos, ar_region, aw_cache, aw_qos, aw_region, w_strb;
   logic [AXI_USER_WIDTH-1:0] ar_user, aw_user, w_user, r_user, b_user;
   logic           ar_ready, r_valid, r_last, aw_ready, w_ready, b_valid;
   logic [31:0]    r_data, w_data;

   fm_axi_master #(
      .AXI_ADDR_WIDTH(AW), .AXI_ID_BIT_COUNT(IDW), .AXI_ID(MID), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_axi(clk_axi), .reset_axi(reset_axi),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .rsp_err(rsp_err),
      .master_readMOSI_address(ar_addr), .master_readMOSI_address_ID(ar_id),
      .master_readMOSI_address_valid(ar_valid), .master_readMOSI_ready_for_data(r_ready),
      .master_readMOSI_protection_type(ar_prot), .master_readMOSI_burst_length(ar_len),
      .master_readMOSI_burst_size(ar_size), .master_readMOSI_burst_type(ar_burst),
      .master_readMOSI_lock_type(ar_lock), .master_readMOSI_cache_type(ar_cache),
      .master_readMOSI_qos(ar_qos), .master_readMOSI_region(ar_region),
      .master_readMOSI_address_user(ar_user),
      .master_readMISO_ready_for_address(ar_ready), .master_readMISO_data_ID(r_id),
      .master_readMISO_data(r_data), .master_readMISO_data_valid(r_valid),
      .master_readMISO_response(r_resp), .master_readMISO_last(r_last),
      .master_readMISO_data_user(r_user),
      .master_writeMOSI_address(aw_addr), .master_writeMOSI_address_ID(aw_id),
      .master_writeMOSI_address_valid(aw_valid), .master_writeMOSI_write_ID(w_id),
      .master_writeMOSI_data(w_data), .master_writeMOSI_data_valid(w_valid),
      .master_writeMOSI_data_write_strobe(w_strb), .master_writeMOSI_last(w_last),
      .master_writeMOSI_ready_for_response(b_ready),
      .master_writeMOSI_protection_type(aw_prot), .master_writeMOSI_burst_length(aw_len),
      .master_writeMOSI_burst_size(aw_size), .master_writeMOSI_burst_type(aw_burst),
      .master_writeMOSI_lock_type(aw_lock), .master_writeMOSI_cache_type(aw_cache),
      .master_writeMOSI_qos(aw_qos), .master_writeMOSI_region(aw_region),
      .master_writeMOSI_address_user(aw_user), .master_writeMOSI_data_user(w_user),
      .master_writeMISO_ready_for_address(aw_ready), .master_writeMISO_ready_for_data(w_ready),
      .master_writeMISO_response_ID(b_id), .master_writeMISO_response_valid(b_valid),
      .master_writeMISO_response(b_resp), .master_writeMISO_response_user(b_user)
   );

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   // Slave behaviour knobs
   int          s_aw_lat, s_w_lat, s_b_lat, s_ar_lat, s_r_lat;
   logic [1:0]  s_bresp, s_rresp;
   logic [5:0]  s_bid, s_rid;
   logic        s_rlast;
   logic [31:0] s_rdata;

   // Observations from the last transaction
   int          o_aw_cnt, o_w_cnt, o_ar_cnt, o_lat;
   logic        o_no_rsp, o_cr1, o_w_last;
   logic [2:0]  o_v1, o_ar_size;
   logic [1:0]  o_ar_burst;
   logic [7:0]  o_ar_len;
   logic [31:0] o_aw_addr, o_ar_addr, o_w_data;
   logic [5:0]  o_aw_id, o_w_id, o_ar_id;
   logic [3:0]  o_w_strb;

   task automatic slave_idle();
      aw_ready = 0; w_ready = 0; b_valid = 0; ar_ready = 0; r_valid = 0;
      b_id = '0; b_resp = '0; r_id = '0; r_data = '0; r_resp = '0; r_last = 0;
   endtask

   task automatic slave_cfg(input int awl, input int wl, input int bl, input int arl, input int rl);
      s_aw_lat = awl; s_w_lat = wl; s_b_lat = bl; s_ar_lat = arl; s_r_lat = rl;
      s_bresp = 2'b00; s_bid = 6'(MID); s_rresp = 2'b00; s_rid = 6'(MID); s_rlast = 1;
      s_rdata = 32'h0;
   endtask

   // Issues one command and plays the slave until rsp_valid is seen or max_cyc elapses.
   task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int max_cyc);
      int   aw_age, w_age, ar_age, b_age, r_age;
      logic b_done, r_done;
      aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0; b_done = 0; r_done = 0;
      o_aw_cnt = 0; o_w_cnt = 0; o_ar_cnt = 0; o_lat = 0; o_no_rsp = 1; o_cr1 = 1; o_v1 = '0;
      @(negedge clk_axi);
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      for (int i = 0; i < max_cyc && !cmd_ready; i++) @(negedge clk_axi);
      if (!cmd_ready) begin
         cmd_valid = 0;
         return;
      end
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(negedge clk_axi);
         cmd_valid = 0;
         if (cyc == 1) begin
            o_cr1 = cmd_ready;
            o_v1  = {aw_valid, w_valid, ar_valid};
         end
         if (rsp_valid) begin
            o_no_rsp = 0;
            o_lat    = cyc;
            break;
         end
         if (o_aw_cnt > 0 && o_w_cnt > 0 && !b_done) begin
            b_age++;
            b_valid = (b_age > s_b_lat);
         end else b_valid = 0;
         b_id = s_bid; b_resp = s_bresp;
         if (b_valid && b_ready) b_done = 1;
         if (o_ar_cnt > 0 && !r_done) begin
            r_age++;
            r_valid = (r_age > s_r_lat);
         end else r_valid = 0;
         r_id = s_rid; r_resp = s_rresp; r_last = s_rlast; r_data = s_rdata;
         if (r_valid && r_ready) r_done = 1;
         if (aw_valid) aw_age++;
         aw_ready = aw_valid && (aw_age > s_aw_lat);
         if (aw_valid && aw_ready) begin
            o_aw_cnt++; o_aw_addr = aw_addr; o_aw_id = aw_id;
         end
         if (w_valid) w_age++;
         w_ready = w_valid && (w_age > s_w_lat);
         if (w_valid && w_ready) begin
            o_w_cnt++; o_w_data = w_data; o_w_strb = w_strb; o_w_last = w_last; o_w_id = w_id;
         end
         if (ar_valid) ar_age++;
         ar_ready = ar_valid && (ar_age > s_ar_lat);
         if (ar_valid && ar_ready) begin
            o_ar_cnt++; o_ar_addr = ar_addr; o_ar_id = ar_id;
            o_ar_size = ar_size; o_ar_burst = ar_burst; o_ar_len = ar_len;
         end
      end
      slave_idle();
   endtask

   task automatic ack_rsp();
      @(negedge clk_axi);
      rsp_ready = 1;
      @(negedge clk_axi);
      rsp_ready = 0;
   endtask

   task automatic test_reset();
      reset_axi = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 0; r_user = '0; b_user = '0;
      slave_idle();
      repeat (3) @(negedge clk_axi);
      checks++;
      if ({cmd_ready, rsp_valid, ar_valid, r_ready, aw_valid, w_valid, b_ready} !== 7'b0) begin
         errors++; $display("FAIL reset_handshakes got %b want 0000000",
            {cmd_ready, rsp_valid, ar_valid, r_ready, aw_valid, w_valid, b_ready});
      end
      checks++;
      if ({rsp_rdata, rsp_resp, rsp_err, ar_addr, w_data, w_strb} !== '0) begin
         errors++; $display("FAIL reset_data got rdata=%h resp=%b err=%b addr=%h wdata=%h",
            rsp_rdata, rsp_resp, rsp_err, ar_addr, w_data);
      end
      reset_axi = 0;
      @(negedge clk_axi);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_cmd_ready_rise got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_write_wready_first();
      slave_cfg(2, 0, 0, 0, 0);
      sb.push_back('{rdata: 32'h0, resp: 2'b00, err: 1'b0});
      run_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 50);
      checks++;
      if (o_no_rsp !== 1'b0) begin errors++; $display("FAIL wr_no_response got none want rsp_valid"); end
      checks++;
      if (o_v1 !== 3'b110) begin errors++; $display("FAIL wr_valids_together got %b want 110", o_v1); end
      checks++;
      if (o_aw_cnt != 1 || o_w_cnt != 1) begin
         errors++; $display("FAIL wr_beat_counts got aw=%0d w=%0d want 1 1", o_aw_cnt, o_w_cnt);
      end
      checks++;
      if ({o_aw_addr, o_aw_id, o_w_id} !== {32'h10, 6'(MID), 6'(MID)}) begin
         errors++; $display("FAIL wr_aw_payload got addr=%h awid=%0d wid=%0d want 10 %0d %0d",
            o_aw_addr, o_aw_id, o_w_id, MID, MID);
      end
      checks++;
      if ({o_w_data, o_w_strb, o_w_last} !== {32'hDEAD_BEEF, 4'hF, 1'b1}) begin
         errors++; $display("FAIL wr_w_payload got data=%h strb=%h last=%b want deadbeef f 1",
            o_w_data, o_w_strb, o_w_last);
      end
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_resp, rsp_err} !== {e.rdata, e.resp, e.err}) begin
         errors++; $display("FAIL wr_rsp got rdata=%h resp=%b err=%b want %h %b %b",
            rsp_rdata, rsp_resp, rsp_err, e.rdata, e.resp, e.err);
      end
      ack_rsp();
   endtask

   task automatic test_read_wait();
      slave_cfg(0, 0, 0, 0, 5);
      s_rdata = 32'hDEAD_BEEF;
      sb.push_back('{rdata: 32'hDEAD_BEEF, resp: 2'b00, err: 1'b0});
      run_txn(0, 32'h0000_0010, 32'h0, 4'h0, 50);
      checks++;
      if (o_no_rsp !== 1'b0) begin errors++; $display("FAIL rd_no_response got none want rsp_valid"); end
      checks++;
      if (o_v1 !== 3'b001 || o_ar_cnt != 1) begin
         errors++; $display("FAIL rd_ar_beats got valids=%b ar=%0d want 001 1", o_v1, o_ar_cnt);
      end
      checks++;
      if ({o_ar_addr, o_ar_id, o_ar_size, o_ar_burst, o_ar_len} !==
          {32'h10, 6'(MID), 3'b010, 2'b01, 8'h00}) begin
         errors++; $display("FAIL rd_ar_payload got addr=%h id=%0d size=%b burst=%b len=%0d",
            o_ar_addr, o_ar_id, o_ar_size, o_ar_burst, o_ar_len);
      end
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_resp, rsp_err} !== {e.rdata, e.resp, e.err}) begin
         errors++; $display("FAIL rd_rsp got rdata=%h resp=%b err=%b want %h %b %b",
            rsp_rdata, rsp_resp, rsp_err, e.rdata, e.resp, e.err);
      end
      ack_rsp();
   endtask

   task automatic test_errors();
      // {write, resp, id, last, data} -> expected {resp, err}
      for (int k = 0; k < 4; k++) begin
         slave_cfg(0, 1, 1, 1, 2);
         case (k)
            0: begin s_rresp = 2'b11; s_rid = 6'(MID + 1); s_rdata = 32'h0BAD_F00D; end
            1: begin s_rlast = 0; s_rdata = 32'h1234_5678; end
            2: begin s_bresp = 2'b10; s_bid = 6'(MID + 1); end
            default: begin s_bresp = 2'b11; end
         endcase
         sb.push_back('{rdata: (k < 2) ? s_rdata : 32'h0,
                        resp:  (k < 2) ? s_rresp : s_bresp,
                        err:   (k != 3)});
         run_txn(k >= 2, 32'h40 + 32'(k * 4), 32'hA5A5_0000 + 32'(k), 4'h3, 50);
         checks++;
         if (o_no_rsp !== 1'b0) begin errors++; $display("FAIL err_case%0d_no_response", k); end
         e = sb.pop_front();
         checks++;
         if ({rsp_rdata, rsp_resp, rsp_err} !== {e.rdata, e.resp, e.err}) begin
            errors++; $display("FAIL err_case%0d_rsp got rdata=%h resp=%b err=%b want %h %b %b",
               k, rsp_rdata, rsp_resp, rsp_err, e.rdata, e.resp, e.err);
         end
         ack_rsp();
      end
   endtask

   task automatic test_zero_wait();
      for (int k = 0; k < 2; k++) begin
         slave_cfg(0, 0, 0, 0, 0);
         s_rdata = 32'hCAFE_0001;
         sb.push_back('{rdata: (k == 0) ? 32'hCAFE_0001 : 32'h0, resp: 2'b00, err: 1'b0});
         run_txn(k == 1, 32'h100, 32'h5555_AAAA, 4'h1, 50);
         checks++;
         if (o_lat != 3) begin
            errors++; $display("FAIL zero_wait_latency_%s got %0d want 3", (k == 1) ? "wr" : "rd", o_lat);
         end
         checks++;
         if (o_cr1 !== 1'b0) begin errors++; $display("FAIL zero_wait_cmd_ready_after_accept got %b want 0", o_cr1); end
         e = sb.pop_front();
         checks++;
         if ({rsp_rdata, rsp_resp, rsp_err} !== {e.rdata, e.resp, e.err}) begin
            errors++; $display("FAIL zero_wait_rsp%0d got rdata=%h resp=%b err=%b want %h %b %b",
               k, rsp_rdata, rsp_resp, rsp_err, e.rdata, e.resp, e.err);
         end
         ack_rsp();
      end
   endtask

   task automatic test_rsp_hold();
      slave_cfg(0, 0, 0, 1, 1);
      s_rdata = 32'h7777_1234; s_rresp = 2'b10;
      sb.push_back('{rdata: 32'h7777_1234, resp: 2'b10, err: 1'b0});
      run_txn(0, 32'h20, 32'h0, 4'h0, 50);
      e = sb.pop_front();
      for (int c = 0; c < 10; c++) begin
         checks++;
         if ({rsp_valid, rsp_rdata, rsp_resp, rsp_err, cmd_ready} !== {1'b1, e.rdata, e.resp, e.err, 1'b0}) begin
            errors++; $display("FAIL hold_cycle%0d got v=%b rdata=%h resp=%b err=%b cr=%b want 1 %h %b %b 0",
               c, rsp_valid, rsp_rdata, rsp_resp, rsp_err, cmd_ready, e.rdata, e.resp, e.err);
         end
         @(negedge clk_axi);
      end
      rsp_ready = 1;
      @(negedge clk_axi);
      rsp_ready = 0;
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         errors++; $display("FAIL hold_release got v=%b cr=%b want 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      slave_cfg(0, 0, 0, 0, 1000);
      run_txn(0, 32'h30, 32'h0, 4'h0, 6);
      checks++;
      if ({o_no_rsp, r_ready} !== 2'b11) begin
         errors++; $display("FAIL midrst_in_rd_data got no_rsp=%b rready=%b want 1 1", o_no_rsp, r_ready);
      end
      reset_axi = 1;
      @(negedge clk_axi);
      reset_axi = 0;
      checks++;
      if ({cmd_ready, rsp_valid, ar_valid, r_ready, aw_valid, w_valid, b_ready, rsp_rdata, rsp_resp, rsp_err, ar_addr} !== '0) begin
         errors++; $display("FAIL midrst_outputs got cr=%b v=%b arv=%b rr=%b addr=%h want all 0",
            cmd_ready, rsp_valid, ar_valid, r_ready, ar_addr);
      end
      seen = 0;
      repeat (5) begin
         @(negedge clk_axi);
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL midrst_spurious_rsp got %0d cycles want 0", seen); end
      slave_cfg(1, 0, 2, 0, 0);
      sb.push_back('{rdata: 32'h0, resp: 2'b00, err: 1'b0});
      run_txn(1, 32'h44, 32'h0102_0304, 4'hC, 50);
      e = sb.pop_front();
      checks++;
      if ({o_no_rsp, o_aw_cnt[1:0], o_w_cnt[1:0], o_w_data, rsp_resp, rsp_err} !==
          {1'b0, 2'd1, 2'd1, 32'h0102_0304, e.resp, e.err}) begin
         errors++; $display("FAIL midrst_recover got no_rsp=%b aw=%0d w=%0d wdata=%h resp=%b err=%b",
            o_no_rsp, o_aw_cnt, o_w_cnt, o_w_data, rsp_resp, rsp_err);
      end
      ack_rsp();
   endtask

`ifdef FM_AXI_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      int arv;
      slave_cfg(0, 0, 0, 1000, 0);
      sb.push_back('{rdata: 32'h0, resp: 2'b10, err: 1'b1});
      run_txn(0, 32'h50, 32'h0, 4'h0, 60);
      checks++;
      if (o_no_rsp !== 1'b0 || o_lat < 16 || o_lat > 18) begin
         errors++; $display("FAIL timeout_latency got no_rsp=%b lat=%0d want 0 16..18", o_no_rsp, o_lat);
      end
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_resp, rsp_err} !== {e.rdata, e.resp, e.err}) begin
         errors++; $display("FAIL timeout_rsp got rdata=%h resp=%b err=%b want %h %b %b",
            rsp_rdata, rsp_resp, rsp_err, e.rdata, e.resp, e.err);
      end
      arv = 0;
      if (ar_valid) arv++;
      ack_rsp();
      repeat (4) begin
         @(negedge clk_axi);
         if (ar_valid) arv++;
      end
      checks++;
      if (arv != 0) begin errors++; $display("FAIL timeout_arvalid_dropped got %0d high cycles want 0", arv); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL global_time_limit reached want completion");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_write_wready_first();
      test_read_wait();
      test_errors();
      test_zero_wait();
      test_rsp_hold();
      test_reset_mid();
`ifdef FM_AXI_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
